// File: rtl/monitor_pkg.sv
// Shared types for the CPU run monitor: FSM states, verdict error codes, saturating add.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package monitor_pkg;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    RUN   = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } monitor_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_RESET_PC  = 2'd1,
    ERR_TIMEOUT   = 2'd2,
    ERR_SIGNATURE = 2'd3
  } monitor_err_t;

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/commit_popcount.sv
// Counts how many commit channels retire an instruction this cycle.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the strobe vector.
module commit_popcount #(
  parameter int CHANNELS = 2,
  parameter int CW       = $clog2(CHANNELS + 1)
) (
  input  logic [CHANNELS-1:0] valid,
  output logic [CW-1:0]       count
);

  // Ripple-add the strobes; CHANNELS is tiny so a linear chain is fine.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count = count + CW'(valid[i]);
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor beside the core: reset-PC check, cycle/commit counters, commit watchdog, halt detection, latched verdict.
// Latency: state moves on the edge that samples a condition; done/pass/errCode latch one edge later.
// Backpressure: none; inputs are sampled every rising edge. Optional trace: define CPU_RUN_MONITOR_TRACE_EN.
module cpu_run_monitor
  import monitor_pkg::*;
#(
  parameter int                WIDTH       = 31,
  parameter int                REG         = 4,
  parameter int                CHANNELS    = 2,
  parameter logic [WIDTH:0]    RESET_PC    = '0,
  parameter int                TIMEOUT     = 1024,
  parameter int                HALT_REPEAT = 4,
  parameter logic [REG:0]      SIG_REG     = 10,
  parameter logic [WIDTH:0]    SIG_PASS    = 1
) (
  input  logic                            clk,
  input  logic                            globalResetN,
  input  logic [WIDTH:0]                  nextPC,
  input  logic [CHANNELS-1:0]             commitValid,
  input  logic [CHANNELS*(REG+1)-1:0]     commitDest,
  input  logic [CHANNELS*(WIDTH+1)-1:0]   commitResult,
  output logic [1:0]                      state,
  output logic [31:0]                     cycleCount,
  output logic [31:0]                     commitCount,
  output logic                            done,
  output logic                            pass,
  output logic [1:0]                      errCode
);

  localparam int CW  = $clog2(CHANNELS + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int STW = $clog2(HALT_REPEAT + 1);

  monitor_state_t  cur_state, nxt_state;
  monitor_err_t    err_q, err_next;
  logic [CW-1:0]   ncommit;
  logic            any_commit;
  logic [WIDTH:0]  prev_pc;
  logic [WIDTH:0]  sig_value, sig_next;
  logic [WDW-1:0]  wd_cnt, wd_next;
  logic [STW-1:0]  stable_cnt, stable_next;
  logic [31:0]     cyc_next, cmt_next;

  commit_popcount #(
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_popcount (
    .valid (commitValid),
    .count (ncommit)
  );

  assign any_commit = |commitValid;
  assign state      = cur_state;

  // Next-state, counter, watchdog, halt and signature evaluation.
  always_comb begin
    nxt_state   = cur_state;
    err_next    = err_q;
    wd_next     = wd_cnt;
    stable_next = stable_cnt;
    sig_next    = sig_value;
    cyc_next    = cycleCount;
    cmt_next    = commitCount;
    case (cur_state)
      CHECK: begin
        if (nextPC == RESET_PC) begin
          nxt_state = RUN;
        end else begin
          nxt_state = FAIL;
          err_next  = ERR_RESET_PC;
        end
      end
      RUN: begin
        cyc_next    = sat_add32(cycleCount, 32'd1);
        cmt_next    = sat_add32(commitCount, 32'(ncommit));
        wd_next     = any_commit ? '0 : wd_cnt + 1'b1;
        stable_next = (nextPC == prev_pc && !any_commit) ? stable_cnt + 1'b1 : '0;
        // Ascending scan so the youngest matching channel overwrites older ones.
        for (int i = 0; i < CHANNELS; i++) begin
          if (commitValid[i] && SIG_REG != '0 &&
              commitDest[i*(REG+1) +: REG+1] == SIG_REG) begin
            sig_next = commitResult[i*(WIDTH+1) +: WIDTH+1];
          end
        end
        // Halt takes priority over a coincident watchdog expiry.
        if (stable_next == STW'(HALT_REPEAT)) begin
          if (sig_next == SIG_PASS) begin
            nxt_state = PASS;
          end else begin
            nxt_state = FAIL;
            err_next  = ERR_SIGNATURE;
          end
        end else if (wd_next == WDW'(TIMEOUT)) begin
          nxt_state = FAIL;
          err_next  = ERR_TIMEOUT;
        end
      end
      default: begin
        nxt_state = cur_state;
      end
    endcase
  end

  // State, counters and tracking registers; terminal states hold everything.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      cur_state   <= CHECK;
      err_q       <= ERR_NONE;
      cycleCount  <= '0;
      commitCount <= '0;
      wd_cnt      <= '0;
      stable_cnt  <= '0;
      sig_value   <= '0;
      prev_pc     <= '0;
    end else begin
      cur_state   <= nxt_state;
      err_q       <= err_next;
      cycleCount  <= cyc_next;
      commitCount <= cmt_next;
      wd_cnt      <= wd_next;
      stable_cnt  <= stable_next;
      sig_value   <= sig_next;
      prev_pc     <= nextPC;
    end
  end

  // Verdict latches on the first edge spent in a terminal state.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      errCode <= '0;
    end else if (!done && (cur_state == PASS || cur_state == FAIL)) begin
      done    <= 1'b1;
      pass    <= (cur_state == PASS);
      errCode <= err_q;
    end
  end

`ifdef CPU_RUN_MONITOR_TRACE_EN
  // Simulation trace of retirements and the verdict transition.
  always @(posedge clk) begin
    if (globalResetN) begin
      if (cur_state == RUN) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (commitValid[i]) begin
            $display("[cpu_run_monitor] cyc=%0d ch=%0d dest=x%0d result=%h",
                     cycleCount, i, commitDest[i*(REG+1) +: REG+1],
                     commitResult[i*(WIDTH+1) +: WIDTH+1]);
          end
        end
      end
      if ((cur_state == CHECK || cur_state == RUN) &&
          (nxt_state == PASS || nxt_state == FAIL)) begin
        $display("[cpu_run_monitor] verdict %s err=%0d cycles=%0d commits=%0d",
                 (nxt_state == PASS) ? "pass" : "fail", err_next, cyc_next, cmt_next);
      end
    end
  end
`endif

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Cycle-accurate run monitor that sits beside the `RISCV` core in simulation and FPGA bring-up builds. It checks the post-reset fetch address and counts cycles and retirements across a configurable number of commit channels. It runs a commit watchdog and detects program end as a fetch self-loop. It reports a latched pass/fail verdict with an error code, replacing ad-hoc `assert`/`$display` checks in top-level benches.

## Interface
- `WIDTH`, 31: MSB index of data/PC words (words are WIDTH+1 bits).
- `REG`, 4: MSB index of register-destination field (5-bit dest).
- `CHANNELS`, 2: number of commit channels monitored (1..4).
- `RESET_PC`, 0: required `nextPC` in first cycle after reset release.
- `TIMEOUT`, 1024: max cycles without any commit before failure (≥2).
- `HALT_REPEAT`, 4: consecutive cycles of unchanged `nextPC` with no commit that constitute halt (≥2).
- `SIG_REG`, 10: architectural register holding the test signature (a0).
- `SIG_PASS`, 1: signature value meaning pass.
- `clk`  in  1  clock, all state on rising edge.
- `globalResetN`  in  1  asynchronous, active-low reset.
- `nextPC`  in  WIDTH+1  core fetch address.
- `commitValid`  in  CHANNELS  per-channel retirement strobe; channel 0 oldest.
- `commitDest`  in  CHANNELS×(REG+1)  per-channel destination register.
- `commitResult`  in  CHANNELS×(WIDTH+1)  per-channel written value.
- `state`  out  2  current FSM state.
- `cycleCount`  out  32  cycles spent in RUN, saturating.
- `commitCount`  out  32  total retirements, saturating.
- `done`  out  1  verdict latched.
- `pass`  out  1  verdict is pass (valid when `done`).
- `errCode`  out  2  0 none, 1 bad reset PC, 2 timeout, 3 bad signature.

## Operation
- States: CHECK(0), RUN(1), PASS(2), FAIL(3). Reset forces CHECK; all counters, `sigValue`, `done`, `pass`, `errCode` cleared.
- CHECK: one cycle. `nextPC == RESET_PC` → RUN; else FAIL with errCode 1.
- RUN: `cycleCount`++ each cycle. `commitCount` += popcount(`commitValid`), both saturating at 2^32−1.
- Watchdog: cleared on any cycle with ≥1 commit, else incremented. Reaching TIMEOUT → FAIL, errCode 2. A commit in the same cycle the watchdog would expire wins (no failure).
- Signature: any valid channel with `commitDest == SIG_REG` updates `sigValue`; multiple in one cycle → highest-index (youngest) channel wins. Writes to x0 ignored.
- Halt: `stableCnt` increments when `nextPC` equals the previous cycle's value and no commit occurred; otherwise resets to 0. Reaching HALT_REPEAT → PASS if `sigValue == SIG_PASS`, else FAIL with errCode 3. Timeout and halt in the same cycle → halt evaluated (timeout ignored).
- PASS/FAIL: terminal; counters frozen; `done`=1; only reset exits.

## Timing
- Verdict registered: `done` rises the cycle after the triggering condition is sampled.
- Bad reset PC: `done`=1, errCode 1 at second rising edge after `globalResetN` deasserts.
- Reset assertion mid-run clears all outputs asynchronously, without waiting for a clock.
- Deassertion is assumed synchronised externally.
- Inputs are sampled only on rising edges and need no handshake.

## Configuration
- `CPU_RUN_MONITOR_TRACE_EN` defined: each commit prints cycle, channel, dest, result via `$display`; verdict prints once on entering PASS/FAIL.
- Not defined: no simulation output; logic otherwise identical and synthesizable.

## Structure
- Shared package `monitor_pkg`: `monitor_state_t` enum (CHECK, RUN, PASS, FAIL), `monitor_err_t` enum (NONE, RESET_PC, TIMEOUT, SIGNATURE).
- Sub-module `commit_popcount`: combinational count of `commitValid` bits, parametrised by CHANNELS, ceil(log2(CHANNELS+1)) output.

## Test plan
- `nextPC`=0x4 at reset release, RESET_PC=0 → FAIL, errCode 1, `done` at 2nd edge.
- Commits on both channels for 10 cycles, then PC stuck at 0x40 for 4 cycles with last a0 write = 1 → PASS, commitCount 20.
- Same as previous, but final a0 write = 0 → FAIL, errCode 3.
- Same cycle: ch0 writes a0=5 and ch1 writes a0=1, then halt → PASS (youngest wins).
- PC changing every cycle, no commits, TIMEOUT=16 → FAIL errCode 2 after 16 RUN cycles; commit on cycle 16 instead → stays RUN.
- `globalResetN` pulsed low mid-RUN between edges → `state`=CHECK and counters 0 immediately.
